// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with normal/show-ahead read, level flags and sticky error flags
module fifo_sync #(
    parameter int addr_width = 4,
    parameter int data_width = 8,
    parameter int show_ahead = 0,
    parameter int af_level   = 12,
    parameter int ae_level   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic [data_width-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [data_width-1:0] q,
    output logic [addr_width:0]   usedw,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << addr_width;
    localparam logic [addr_width:0] DEPTH_W = (addr_width+1)'(DEPTH);
    localparam logic [addr_width:0] AF_W    = (addr_width+1)'(af_level);
    localparam logic [addr_width:0] AE_W    = (addr_width+1)'(ae_level);

    logic [data_width-1:0] mem_q [DEPTH];
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc, wr_en;
    logic [data_width-1:0] head;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_W);
    assign almost_empty = (count_q <= AE_W);
    assign almost_full  = (count_q >= AF_W);
    assign usedw        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign head         = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign wr_acc = wrreq && (!full || rdreq);
    assign rd_acc = rdreq && !empty;
    assign wr_en  = wr_acc && !sclr && !rst;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (sclr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wrreq && !wr_acc) overflow_d  = 1'b1;
            if (rdreq && empty)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data;
    end

    generate
        if (show_ahead != 0) begin : g_show_ahead
            assign q = empty ? '0 : head;
        end else begin : g_normal
            logic [data_width-1:0] q_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_q <= '0;
                end else if (sclr) begin
                    q_q <= '0;
                end else if (rd_acc) begin
                    q_q <= head;
                end
            end
            assign q = q_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - table-driven bench for fifo_sync in normal and show-ahead modes
module tb_fifo_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_sclr, n_wr, n_rd, s_sclr, s_wr, s_rd;
    logic [7:0] n_data, s_data, n_q, s_q;
    logic [4:0] n_usedw, s_usedw;
    logic       n_empty, n_full, n_ae, n_af, n_ovf, n_udf;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_sync #(.addr_width(4), .data_width(8), .show_ahead(0), .af_level(12), .ae_level(2)) dut_n (
        .clk(clk), .rst(rst), .sclr(n_sclr), .data(n_data), .wrreq(n_wr), .rdreq(n_rd),
        .q(n_q), .usedw(n_usedw), .empty(n_empty), .full(n_full),
        .almost_empty(n_ae), .almost_full(n_af), .overflow(n_ovf), .underflow(n_udf)
    );

    fifo_sync #(.addr_width(4), .data_width(8), .show_ahead(1), .af_level(12), .ae_level(2)) dut_s (
        .clk(clk), .rst(rst), .sclr(s_sclr), .data(s_data), .wrreq(s_wr), .rdreq(s_rd),
        .q(s_q), .usedw(s_usedw), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .overflow(s_ovf), .underflow(s_udf)
    );

    typedef struct {
        logic       sa;
        logic       sclr;
        logic       wr;
        logic       rd;
        logic [7:0] data;
        logic [4:0] usedw;
        logic [7:0] q;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sa, input logic sclr, input logic wr, input logic rd,
                       input logic [7:0] d, input int uw, input logic [7:0] eq,
                       input logic ovf, input logic udf);
        vec_t v;
        v.sa = sa; v.sclr = sclr; v.wr = wr; v.rd = rd; v.data = d;
        v.usedw = 5'(uw);
        v.q     = eq;
        v.empty = (uw == 0);
        v.full  = (uw == 16);
        v.ae    = (uw <= 2);
        v.af    = (uw >= 12);
        v.ovf   = ovf;
        v.udf   = udf;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0b want %0b", nm, idx, act, exp);
        end
    endtask

    task automatic chk5(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %02h want %02h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input logic sa, input int idx, input logic [4:0] uw, input logic [7:0] eq,
                           input logic e, input logic f, input logic ae, input logic af,
                           input logic ovf, input logic udf);
        if (sa) begin
            chk5("sa_usedw", idx, s_usedw, uw);
            chk8("sa_q", idx, s_q, eq);
            chk1("sa_empty", idx, s_empty, e);
            chk1("sa_full", idx, s_full, f);
            chk1("sa_almost_empty", idx, s_ae, ae);
            chk1("sa_almost_full", idx, s_af, af);
            chk1("sa_overflow", idx, s_ovf, ovf);
            chk1("sa_underflow", idx, s_udf, udf);
        end else begin
            chk5("usedw", idx, n_usedw, uw);
            chk8("q", idx, n_q, eq);
            chk1("empty", idx, n_empty, e);
            chk1("full", idx, n_full, f);
            chk1("almost_empty", idx, n_ae, ae);
            chk1("almost_full", idx, n_af, af);
            chk1("overflow", idx, n_ovf, ovf);
            chk1("underflow", idx, n_udf, udf);
        end
    endtask

    task automatic idle_inputs();
        n_sclr = 1'b0; n_wr = 1'b0; n_rd = 1'b0; n_data = 8'h00;
        s_sclr = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_data = 8'h00;
    endtask

    initial begin
        // Normal mode: fill, overflow, drain, flush
        for (int k = 1; k <= 16; k++) add(0, 0, 1, 0, 8'(k), k, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'hAA, 16, 8'h00, 1, 0);
        add(0, 0, 0, 0, 8'h00, 16, 8'h00, 1, 0);
        for (int j = 1; j <= 16; j++) add(0, 0, 0, 1, 8'h00, 16 - j, 8'(j), 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        // Full with simultaneous read and write
        for (int k = 1; k <= 16; k++) add(0, 0, 1, 0, 8'(k), k, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'h55, 16, 8'h01, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 0, 0, 1, 8'h00, 16 - k, 8'(k + 1), 0, 0);
        add(0, 0, 0, 1, 8'h00, 0, 8'h55, 0, 0);
        // Empty with simultaneous read and write
        add(0, 0, 1, 1, 8'h33, 1, 8'h55, 0, 1);
        add(0, 0, 0, 1, 8'h00, 0, 8'h33, 0, 1);
        // Flush while busy; requests alongside sclr are discarded
        for (int k = 1; k <= 5; k++) add(0, 0, 1, 0, 8'(8'h20 + k), k, 8'h33, 0, 1);
        add(0, 1, 1, 1, 8'h99, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h11, 1, 8'h00, 0, 0);
        add(0, 0, 0, 1, 8'h00, 0, 8'h11, 0, 0);
        // Show-ahead mode
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 1, 0, 8'h7E, 1, 8'h7E, 0, 0);
        add(1, 0, 1, 0, 8'h7F, 2, 8'h7E, 0, 0);
        add(1, 0, 0, 1, 8'h00, 1, 8'h7F, 0, 0);
        add(1, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1);
        add(1, 0, 1, 1, 8'h44, 1, 8'h44, 0, 1);
        add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

        // Reset wins over concurrent requests
        rst = 1'b1;
        idle_inputs();
        n_wr = 1'b1; n_rd = 1'b1; n_data = 8'h5A;
        s_wr = 1'b1; s_rd = 1'b1; s_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        chk_all(0, -1, 5'd0, 8'h00, 1, 0, 1, 0, 0, 0);
        chk_all(1, -1, 5'd0, 8'h00, 1, 0, 1, 0, 0, 0);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            idle_inputs();
            if (vecs[i].sa) begin
                s_sclr = vecs[i].sclr; s_wr = vecs[i].wr; s_rd = vecs[i].rd; s_data = vecs[i].data;
            end else begin
                n_sclr = vecs[i].sclr; n_wr = vecs[i].wr; n_rd = vecs[i].rd; n_data = vecs[i].data;
            end
            @(posedge clk);
            #1;
            chk_all(vecs[i].sa, i, vecs[i].usedw, vecs[i].q, vecs[i].empty, vecs[i].full,
                    vecs[i].ae, vecs[i].af, vecs[i].ovf, vecs[i].udf);
        end
        idle_inputs();

        // Mid-operation reset clears contents and the registered q
        n_wr = 1'b1; n_data = 8'h66;
        @(posedge clk);
        #1;
        chk5("pre_rst_usedw", 1000, n_usedw, 5'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all(0, 1001, 5'd0, 8'h00, 1, 0, 1, 0, 0, 0);
        rst = 1'b0;
        n_wr = 1'b0; n_rd = 1'b1;
        @(posedge clk);
        #1;
        chk1("post_rst_underflow", 1002, n_udf, 1'b1);
        chk5("post_rst_usedw", 1002, n_usedw, 5'd0);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
